multicycle_ctrl: RTL and testbench

- Multi-cycle sequencer for the NPC core. Drives instruction fetch, decode, execute, memory access and writeback over one shared memory port.
- The control signal generator supplies the decoded per-instruction controls (mem_rd_en, mem_wr_en, gpr_wr_en, csr_wr_en, illegal) from the latched IR. This block turns them into one-cycle commit strobes.
- Arbitrates the single memory port between fetch and load/store, watchdogs memory responses, counts retired instructions, and halts sticky on faults.

---
 rtl/multicycle_ctrl_if.sv | 20 ++
 rtl/multicycle_ctrl.sv | 151 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Shared memory port between the multi-cycle sequencer and the memory system.
// One request is in flight at a time; responses carry an error flag.
interface multicycle_ctrl_if;
  logic mem_req_valid;
  logic mem_req_ready;
  logic mem_req_sel;
  logic mem_req_wen;
  logic mem_resp_valid;
  logic mem_resp_err;

  modport master (
    output mem_req_valid, mem_req_sel, mem_req_wen,
    input  mem_req_ready, mem_resp_valid, mem_resp_err
  );

  modport slave (
    input  mem_req_valid, mem_req_sel, mem_req_wen,
    output mem_req_ready, mem_resp_valid, mem_resp_err
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// NPC multi-cycle sequencer: fetch/decode/exec/mem/writeback over one memory
// port, with response watchdog, retire counter and sticky fault state.
module multicycle_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TO_W    = 16,
  parameter int TIMEOUT = 256
) (
  input  logic               clk,
  input  logic               rst,
  multicycle_ctrl_if.master  mem,
  input  logic               dec_mem_rd_en,
  input  logic               dec_mem_wr_en,
  input  logic               dec_gpr_wr_en,
  input  logic               dec_csr_wr_en,
  input  logic               dec_illegal,
  output logic               ir_wr_en,
  output logic               mdr_wr_en,
  output logic               gpr_wr_en,
  output logic               csr_wr_en,
  output logic               pc_wr_en,
  output logic               fault,
  output logic [2:0]         fault_cause,
  output logic [CNT_W-1:0]   retire_cnt
);

  typedef enum logic [2:0] {
    FETCH_REQ, FETCH_WAIT, DECODE, EXEC, MEM_REQ, MEM_WAIT, WB, FAULT
  } state_t;

  localparam int TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [TO_W-1:0] TO_LAST = TO_LAST_I[TO_W-1:0];

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_cause, w_cause_nxt;
  logic [TO_W-1:0]  r_wdog;
  logic [CNT_W-1:0] r_retire_cnt;
  logic             r_is_store;
  logic             w_in_wait, w_expire, w_accept;

  assign w_in_wait = (r_state == FETCH_WAIT) || (r_state == MEM_WAIT);
  assign w_accept  = ((r_state == FETCH_REQ) || (r_state == MEM_REQ)) && mem.mem_req_ready;
  assign w_expire  = (TIMEOUT != 0) && w_in_wait && !mem.mem_resp_valid && (r_wdog == TO_LAST);

  always_comb begin
    w_state_nxt       = r_state;
    w_cause_nxt       = r_cause;
    mem.mem_req_valid = 1'b0;
    mem.mem_req_sel   = 1'b0;
    mem.mem_req_wen   = 1'b0;
    ir_wr_en          = 1'b0;
    mdr_wr_en         = 1'b0;
    gpr_wr_en         = 1'b0;
    csr_wr_en         = 1'b0;
    pc_wr_en          = 1'b0;
    fault             = 1'b0;
    fault_cause       = r_cause;
    case (r_state)
      FETCH_REQ: begin
        mem.mem_req_valid = 1'b1;
        if (mem.mem_req_ready) w_state_nxt = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (mem.mem_resp_valid) begin
          if (mem.mem_resp_err) begin
            w_state_nxt = FAULT;
            w_cause_nxt = 3'd1;
          end else begin
            ir_wr_en    = 1'b1;
            w_state_nxt = DECODE;
          end
        end else if (w_expire) begin
          w_state_nxt = FAULT;
          w_cause_nxt = 3'd5;
        end
      end
      DECODE: begin
        if (dec_illegal) begin
          w_state_nxt = FAULT;
          w_cause_nxt = 3'd2;
        end else begin
          w_state_nxt = EXEC;
        end
      end
      EXEC: w_state_nxt = (dec_mem_rd_en || dec_mem_wr_en) ? MEM_REQ : WB;
      MEM_REQ: begin
        mem.mem_req_valid = 1'b1;
        mem.mem_req_sel   = 1'b1;
        mem.mem_req_wen   = r_is_store;
        if (mem.mem_req_ready) w_state_nxt = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (mem.mem_resp_valid) begin
          if (mem.mem_resp_err) begin
            w_state_nxt = FAULT;
            w_cause_nxt = r_is_store ? 3'd4 : 3'd3;
          end else begin
            mdr_wr_en   = !r_is_store;
            w_state_nxt = WB;
          end
        end else if (w_expire) begin
          w_state_nxt = FAULT;
          w_cause_nxt = 3'd5;
        end
      end
      WB: begin
        pc_wr_en    = 1'b1;
        gpr_wr_en   = dec_gpr_wr_en;
        csr_wr_en   = dec_csr_wr_en;
        w_state_nxt = FETCH_REQ;
      end
      FAULT: fault = 1'b1;
      default: w_state_nxt = FAULT;
    endcase
    // Hold every output quiet while reset is asserted, whatever the state
    if (rst) begin
      mem.mem_req_valid = 1'b0;
      mem.mem_req_sel   = 1'b0;
      mem.mem_req_wen   = 1'b0;
      ir_wr_en          = 1'b0;
      mdr_wr_en         = 1'b0;
      gpr_wr_en         = 1'b0;
      csr_wr_en         = 1'b0;
      pc_wr_en          = 1'b0;
      fault             = 1'b0;
      fault_cause       = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= FETCH_REQ;
      r_cause      <= 3'd0;
      r_wdog       <= '0;
      r_retire_cnt <= '0;
      r_is_store   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cause <= w_cause_nxt;
      // Both rd and wr set counts as a store
      if (r_state == EXEC) r_is_store <= dec_mem_wr_en;
      if (r_state == WB) r_retire_cnt <= r_retire_cnt + CNT_W'(1);
      if (w_accept)
        r_wdog <= '0;
      else if (w_in_wait && !mem.mem_resp_valid && (r_wdog != '1))
        r_wdog <= r_wdog + TO_W'(1);
    end
  end

  assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with CNT_W=4 and TIMEOUT=4 so counter
// wrap and watchdog expiry are reachable in a short run.
module tb_multicycle_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       dec_mem_rd_en, dec_mem_wr_en, dec_gpr_wr_en, dec_csr_wr_en, dec_illegal;
  logic       ir_wr_en, mdr_wr_en, gpr_wr_en, csr_wr_en, pc_wr_en, fault;
  logic [2:0] fault_cause;
  logic [3:0] retire_cnt;

  int errors = 0;
  int checks = 0;
  int n_req = 0, n_ir = 0, n_mdr = 0, n_pc = 0;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.CNT_W(4), .TO_W(16), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .mem(bus.master),
    .dec_mem_rd_en(dec_mem_rd_en), .dec_mem_wr_en(dec_mem_wr_en),
    .dec_gpr_wr_en(dec_gpr_wr_en), .dec_csr_wr_en(dec_csr_wr_en),
    .dec_illegal(dec_illegal),
    .ir_wr_en(ir_wr_en), .mdr_wr_en(mdr_wr_en), .gpr_wr_en(gpr_wr_en),
    .csr_wr_en(csr_wr_en), .pc_wr_en(pc_wr_en), .fault(fault),
    .fault_cause(fault_cause), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      n_req += int'(bus.mem_req_valid);
      n_ir  += int'(ir_wr_en);
      n_mdr += int'(mdr_wr_en);
      n_pc  += int'(pc_wr_en);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic set_dec(input bit rd, input bit wr, input bit gpr, input bit csr, input bit ill);
    dec_mem_rd_en = rd; dec_mem_wr_en = wr; dec_gpr_wr_en = gpr;
    dec_csr_wr_en = csr; dec_illegal = ill;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
  endtask

  // Entered in FETCH_REQ; memory-stage ready is held low for `stall` cycles
  task automatic mem_instr(input bit st, input int stall);
    int p0, m0;
    p0 = n_pc; m0 = n_mdr;
    set_dec(!st, st, !st, 1'b0, 1'b0);
    bus.mem_req_ready = 1'b1; bus.mem_resp_valid = 1'b1; bus.mem_resp_err = 1'b0;
    repeat (4) nxt();
    bus.mem_req_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      settle();
      chk("memreq_stall_valid", 32'(bus.mem_req_valid), 32'd1);
      chk("memreq_stall_sel", 32'(bus.mem_req_sel), 32'd1);
      chk("memreq_stall_wen", 32'(bus.mem_req_wen), 32'(st));
      nxt();
    end
    bus.mem_req_ready = 1'b1;
    settle();
    chk("memreq_accept_wen", 32'(bus.mem_req_wen), 32'(st));
    nxt();
    settle();
    chk("memwait_mdr", 32'(mdr_wr_en), 32'(!st));
    nxt();
    settle();
    chk("mem_wb_pc", 32'(pc_wr_en), 32'd1);
    chk("mem_wb_gpr", 32'(gpr_wr_en), 32'(!st));
    nxt();
    chk("mem_pc_pulses", 32'(n_pc - p0), 32'd1);
    chk("mem_mdr_pulses", 32'(n_mdr - m0), 32'(!st));
  endtask

  initial begin
    int r0, q0, i0;
    rst = 1'b1;
    set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_err = 1'b0;
    nxt(); nxt();
    settle();
    chk("rst_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_cause", 32'(fault_cause), 32'd0);
    chk("rst_retire", 32'(retire_cnt), 32'd0);
    chk("rst_pc", 32'(pc_wr_en), 32'd0);
    nxt();
    rst = 1'b0;
    settle();
    chk("fetch_valid", 32'(bus.mem_req_valid), 32'd1);
    chk("fetch_sel", 32'(bus.mem_req_sel), 32'd0);
    chk("fetch_wen", 32'(bus.mem_req_wen), 32'd0);
    nxt();
    do_reset();

    // ADDI stream: one retire every 5 cycles
    set_dec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.mem_req_ready = 1'b1; bus.mem_resp_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      settle();
      chk("addi_pc", 32'(pc_wr_en), 32'(i % 5 == 4));
      chk("addi_gpr", 32'(gpr_wr_en), 32'(i % 5 == 4));
      chk("addi_ir", 32'(ir_wr_en), 32'(i % 5 == 1));
      chk("addi_sel", 32'(bus.mem_req_sel), 32'd0);
      nxt();
    end
    chk("addi_retire", 32'(retire_cnt), 32'd10);

    mem_instr(1'b0, 3);
    mem_instr(1'b1, 3);
    chk("mem_retire", 32'(retire_cnt), 32'd12);

    // Illegal opcode: sticky fault, nothing moves afterwards
    set_dec(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    nxt(); nxt();
    settle();
    chk("decode_no_fault", 32'(fault), 32'd0);
    nxt();
    settle();
    chk("illegal_fault", 32'(fault), 32'd1);
    chk("illegal_cause", 32'(fault_cause), 32'd2);
    nxt();
    r0 = n_pc; q0 = n_req; i0 = n_ir;
    repeat (20) nxt();
    chk("fault_no_req", 32'(n_req - q0), 32'd0);
    chk("fault_no_pc", 32'(n_pc - r0), 32'd0);
    chk("fault_no_ir", 32'(n_ir - i0), 32'd0);
    chk("fault_retire_frozen", 32'(retire_cnt), 32'd12);
    chk("fault_sticky_cause", 32'(fault_cause), 32'd2);
    do_reset();
    settle();
    chk("post_rst_fault", 32'(fault), 32'd0);
    chk("post_rst_retire", 32'(retire_cnt), 32'd0);
    chk("post_rst_valid", 32'(bus.mem_req_valid), 32'd1);
    nxt();
    do_reset();

    // Watchdog expiry after 4 silent wait cycles
    set_dec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.mem_resp_valid = 1'b0;
    nxt();
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("wdog_wait_no_fault", 32'(fault), 32'd0);
      nxt();
    end
    settle();
    chk("wdog_fault", 32'(fault), 32'd1);
    chk("wdog_cause", 32'(fault_cause), 32'd5);
    nxt();
    do_reset();

    // Response on the expiry cycle wins
    set_dec(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    nxt();
    repeat (3) nxt();
    bus.mem_resp_valid = 1'b1;
    settle();
    chk("wdog_late_ir", 32'(ir_wr_en), 32'd1);
    nxt();
    settle();
    chk("wdog_late_no_fault", 32'(fault), 32'd0);
    nxt(); nxt();
    settle();
    chk("wb_csr", 32'(csr_wr_en), 32'd1);
    nxt();
    chk("late_retire", 32'(retire_cnt), 32'd1);
    do_reset();

    // Fetch error
    set_dec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.mem_resp_err = 1'b1;
    nxt();
    settle();
    chk("fetch_err_no_ir", 32'(ir_wr_en), 32'd0);
    nxt();
    settle();
    chk("fetch_err_cause", 32'(fault_cause), 32'd1);
    nxt();
    do_reset();

    // Load error
    set_dec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.mem_resp_err = 1'b0;
    repeat (5) nxt();
    bus.mem_resp_err = 1'b1;
    settle();
    chk("load_err_no_mdr", 32'(mdr_wr_en), 32'd0);
    nxt();
    settle();
    chk("load_err_cause", 32'(fault_cause), 32'd3);
    nxt();
    do_reset();

    // Store error with rd and wr both set (treated as store)
    set_dec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.mem_resp_err = 1'b0;
    repeat (4) nxt();
    settle();
    chk("both_wen", 32'(bus.mem_req_wen), 32'd1);
    nxt();
    bus.mem_resp_err = 1'b1;
    nxt();
    settle();
    chk("store_err_cause", 32'(fault_cause), 32'd4);
    nxt();
    do_reset();

    // Reset in MEM_WAIT; stale response afterwards is ignored
    set_dec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.mem_resp_err = 1'b0;
    repeat (4) nxt();
    bus.mem_resp_valid = 1'b0;
    nxt();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    bus.mem_resp_valid = 1'b1; bus.mem_req_ready = 1'b0;
    settle();
    chk("stale_valid", 32'(bus.mem_req_valid), 32'd1);
    chk("stale_sel", 32'(bus.mem_req_sel), 32'd0);
    chk("stale_mdr", 32'(mdr_wr_en), 32'd0);
    nxt();
    settle();
    chk("stale_hold_valid", 32'(bus.mem_req_valid), 32'd1);
    chk("stale_no_fault", 32'(fault), 32'd0);
    nxt();

    // 17 retires wrap a 4-bit counter to 1
    set_dec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.mem_req_ready = 1'b1;
    repeat (17 * 5) nxt();
    chk("wrap_retire", 32'(retire_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
